// File: rtl/xor_cipher_engine.sv
// Serial XOR cipher: shift in a key and a message bit by bit, XOR the message
// with the replicated key, then shift the ciphertext out MSB first.
module xor_cipher_engine #(
  parameter int KEY_SIZE = 4,
  parameter int MSG_SIZE = 8
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iEn,
  input  logic iData_in,
  input  logic iLoad_key,
  input  logic iLoad_msg,
  input  logic iMode,
  output logic oData_out,
  output logic oValid,
  output logic oDone_flag,
  output logic oBusy,
  output logic oKey_ready
);

  localparam int REP = MSG_SIZE / KEY_SIZE;
  localparam int KCW = $clog2(KEY_SIZE + 1);
  localparam int MCW = $clog2(MSG_SIZE + 1);

  // Stop elaboration on a key/message width combination that cannot tile.
  generate
    if (KEY_SIZE < 1 || MSG_SIZE < 1 || (MSG_SIZE % KEY_SIZE) != 0) begin : g_cfg_err
      $error("xor_cipher_engine: MSG_SIZE must be a positive multiple of KEY_SIZE");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_ENCRYPT, S_SHIFT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [KEY_SIZE-1:0]   key_q,   key_d;
  logic [KCW-1:0]        kcnt_q,  kcnt_d;
  logic [MSG_SIZE-1:0]   msg_q,   msg_d;
  logic [MCW-1:0]        mcnt_q,  mcnt_d;
  logic [MSG_SIZE-1:0]   ct_q,    ct_d;    // unsent ciphertext, next bit at MSB
  logic [MCW-1:0]        bcnt_q,  bcnt_d;  // ciphertext bits already presented
  logic                  dout_q,  dout_d;

  logic                  key_full;
  logic [MSG_SIZE-1:0]   akey;
  logic [MSG_SIZE-1:0]   ct_shl;

  assign key_full = (kcnt_q == KCW'(KEY_SIZE));
  assign akey     = {REP{key_q}};
  assign ct_shl   = ct_q << 1;

  // Next-state logic; everything holds when iEn is low.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    kcnt_d  = kcnt_q;
    msg_d   = msg_q;
    mcnt_d  = mcnt_q;
    ct_d    = ct_q;
    bcnt_d  = bcnt_q;
    dout_d  = dout_q;
    if (iEn) begin
      case (state_q)
        S_IDLE: begin
          // Key load has priority; a simultaneous message bit is dropped.
          if (iLoad_key) begin
            key_d = (key_q << 1) | KEY_SIZE'(iData_in);
            if (!key_full) kcnt_d = kcnt_q + 1'b1;
          end else if (iLoad_msg && key_full) begin
            msg_d  = (msg_q << 1) | MSG_SIZE'(iData_in);
            mcnt_d = mcnt_q + 1'b1;
            if (mcnt_q == MCW'(MSG_SIZE - 1)) state_d = S_ENCRYPT;
          end
        end
        S_ENCRYPT: begin
          ct_d   = msg_q ^ akey;
          dout_d = ct_d[MSG_SIZE-1];
          bcnt_d = MCW'(1);
          mcnt_d = '0;
          // Rolling mode rotates the key after each use.
          if (iMode) key_d = (key_q << 1) | (key_q >> (KEY_SIZE - 1));
          state_d = S_SHIFT;
        end
        S_SHIFT: begin
          if (bcnt_q == MCW'(MSG_SIZE)) begin
            dout_d  = 1'b0;
            bcnt_d  = '0;
            state_d = S_DONE;
          end else begin
            ct_d   = ct_shl;
            dout_d = ct_shl[MSG_SIZE-1];
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        default: begin
          dout_d  = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset that overrides the enable.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      kcnt_q  <= '0;
      msg_q   <= '0;
      mcnt_q  <= '0;
      ct_q    <= '0;
      bcnt_q  <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      kcnt_q  <= kcnt_d;
      msg_q   <= msg_d;
      mcnt_q  <= mcnt_d;
      ct_q    <= ct_d;
      bcnt_q  <= bcnt_d;
      dout_q  <= dout_d;
    end
  end

  assign oData_out  = dout_q;
  assign oValid     = (state_q == S_SHIFT);
  assign oDone_flag = (state_q == S_DONE);
  assign oBusy      = (state_q != S_IDLE);
  assign oKey_ready = key_full;

endmodule

// File: tb/tb_xor_cipher_engine.sv
// Directed bench for xor_cipher_engine at default sizes (4-bit key, 8-bit message).
module tb_xor_cipher_engine;

  logic iClk = 1'b0;
  logic iRst, iEn, iData_in, iLoad_key, iLoad_msg, iMode;
  logic oData_out, oValid, oDone_flag, oBusy, oKey_ready;

  int checks = 0;
  int failures = 0;

  logic [7:0] cap_ct;
  int         cap_nv;
  int         cap_nd;
  logic       cap_bad_done;

  xor_cipher_engine #(.KEY_SIZE(4), .MSG_SIZE(8)) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iData_in(iData_in),
    .iLoad_key(iLoad_key), .iLoad_msg(iLoad_msg), .iMode(iMode),
    .oData_out(oData_out), .oValid(oValid), .oDone_flag(oDone_flag),
    .oBusy(oBusy), .oKey_ready(oKey_ready)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic do_reset();
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
  endtask

  task automatic send_key(input logic [3:0] k);
    for (int i = 3; i >= 0; i--) begin
      iLoad_key = 1'b1; iData_in = k[i];
      tick();
    end
    iLoad_key = 1'b0; iData_in = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] m);
    for (int i = 7; i >= 0; i--) begin
      iLoad_msg = 1'b1; iData_in = m[i];
      tick();
    end
    iLoad_msg = 1'b0; iData_in = 1'b0;
  endtask

  // Collect ciphertext bits until the done pulse (bounded); optionally
  // wiggle the load strobes the whole time to show they are ignored.
  task automatic capture(input logic toggle);
    for (int i = 0; i < 40; i++) begin
      if (toggle) begin
        iLoad_msg = i[0]; iLoad_key = i[0]; iData_in = 1'b1;
      end
      tick();
      if (oValid) begin
        cap_ct = {cap_ct[6:0], oData_out};
        cap_nv++;
      end
      if (oDone_flag) begin
        cap_nd++;
        if (oValid || oData_out) cap_bad_done = 1'b1;
        break;
      end
    end
    iLoad_msg = 1'b0; iLoad_key = 1'b0; iData_in = 1'b0;
  endtask

  task automatic cap_clear();
    cap_ct = '0; cap_nv = 0; cap_nd = 0; cap_bad_done = 1'b0;
  endtask

  task automatic test_reset();
    iEn = 1'b0;
    do_reset();
    checks++; if ({oData_out, oValid, oDone_flag, oBusy, oKey_ready} !== 5'b0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=00000", {oData_out, oValid, oDone_flag, oBusy, oKey_ready});
    end
    iEn = 1'b1;
  endtask

  task automatic test_static();
    do_reset();
    iMode = 1'b0;
    send_key(4'b1010);
    checks++; if (oKey_ready !== 1'b1) begin
      failures++; $display("FAIL static_key_ready got=%b exp=1", oKey_ready);
    end
    send_msg(8'b11001100);
    checks++; if ({oBusy, oValid} !== 2'b10) begin
      failures++; $display("FAIL static_encrypt_state busy,valid got=%b exp=10", {oBusy, oValid});
    end
    cap_clear();
    capture(1'b0);
    checks++; if (cap_ct !== 8'b01100110) begin
      failures++; $display("FAIL static_ct got=%b exp=01100110", cap_ct);
    end
    checks++; if (cap_nv !== 8) begin
      failures++; $display("FAIL static_valid_count got=%0d exp=8", cap_nv);
    end
    checks++; if (cap_nd !== 1 || cap_bad_done !== 1'b0) begin
      failures++; $display("FAIL static_done got=%0d bad=%b exp=1 bad=0", cap_nd, cap_bad_done);
    end
    tick();
    checks++; if ({oDone_flag, oBusy, oKey_ready} !== 3'b001) begin
      failures++; $display("FAIL static_after_done got=%b exp=001", {oDone_flag, oBusy, oKey_ready});
    end
  endtask

  task automatic test_rolling();
    do_reset();
    iMode = 1'b1;
    send_key(4'b1010);
    send_msg(8'b11001100);
    cap_clear();
    capture(1'b0);
    checks++; if (cap_ct !== 8'b01100110 || cap_nv !== 8) begin
      failures++; $display("FAIL rolling_first got=%b n=%0d exp=01100110 n=8", cap_ct, cap_nv);
    end
    tick();
    send_msg(8'b11001100);
    cap_clear();
    capture(1'b0);
    checks++; if (cap_ct !== 8'b10011001 || cap_nv !== 8) begin
      failures++; $display("FAIL rolling_second got=%b n=%0d exp=10011001 n=8", cap_ct, cap_nv);
    end
    iMode = 1'b0;
  endtask

  task automatic test_no_key();
    logic seen;
    seen = 1'b0;
    do_reset();
    for (int i = 7; i >= 0; i--) begin
      iLoad_msg = 1'b1; iData_in = i[1];
      tick();
      if (oValid || oBusy) seen = 1'b1;
    end
    iLoad_msg = 1'b0; iData_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (oValid || oBusy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin
      failures++; $display("FAIL no_key_activity got=%b exp=0", seen);
    end
    checks++; if (oKey_ready !== 1'b0) begin
      failures++; $display("FAIL no_key_ready got=%b exp=0", oKey_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    do_reset();
    send_key(4'b1010);
    send_msg(8'b11001100);
    tick(); tick(); tick();   // now in the 3rd SHIFT cycle
    checks++; if (oValid !== 1'b1) begin
      failures++; $display("FAIL reset_mid_in_shift got=%b exp=1", oValid);
    end
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    checks++; if ({oData_out, oValid, oDone_flag, oBusy, oKey_ready} !== 5'b0) begin
      failures++; $display("FAIL reset_mid_outputs got=%b exp=00000", {oData_out, oValid, oDone_flag, oBusy, oKey_ready});
    end
    for (int i = 7; i >= 0; i--) begin
      iLoad_msg = 1'b1; iData_in = i[0];
      tick();
      if (oValid || oBusy || oDone_flag) seen = 1'b1;
    end
    iLoad_msg = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (oValid || oBusy || oDone_flag) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin
      failures++; $display("FAIL reset_mid_msg_ignored got=%b exp=0", seen);
    end
  endtask

  task automatic test_enable_freeze();
    logic held_bad;
    held_bad = 1'b0;
    do_reset();
    send_key(4'b1010);
    send_msg(8'b11001100);
    cap_clear();
    for (int i = 0; i < 3; i++) begin
      tick();
      cap_ct = {cap_ct[6:0], oData_out}; cap_nv++;
    end
    iEn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (oData_out !== 1'b1 || oValid !== 1'b1 || oBusy !== 1'b1) held_bad = 1'b1;
    end
    checks++; if (held_bad !== 1'b0) begin
      failures++; $display("FAIL freeze_hold got=%b exp=0", held_bad);
    end
    iEn = 1'b1;
    capture(1'b0);
    checks++; if (cap_ct !== 8'b01100110 || cap_nv !== 8 || cap_nd !== 1) begin
      failures++; $display("FAIL freeze_resume got=%b n=%0d done=%0d exp=01100110 n=8 done=1", cap_ct, cap_nv, cap_nd);
    end
  endtask

  task automatic test_load_conflict();
    do_reset();
    send_key(4'b1010);
    // Both strobes: key takes the bit (key becomes 0101), message ignores it.
    iLoad_key = 1'b1; iLoad_msg = 1'b1; iData_in = 1'b1;
    tick();
    iLoad_key = 1'b0; iLoad_msg = 1'b0; iData_in = 1'b0;
    checks++; if ({oKey_ready, oBusy} !== 2'b10) begin
      failures++; $display("FAIL conflict_idle got=%b exp=10", {oKey_ready, oBusy});
    end
    send_msg(8'b11001100);
    cap_clear();
    capture(1'b1);
    checks++; if (cap_ct !== 8'b10011001 || cap_nv !== 8) begin
      failures++; $display("FAIL conflict_ct got=%b n=%0d exp=10011001 n=8", cap_ct, cap_nv);
    end
    tick();
    send_msg(8'b11001100);
    cap_clear();
    capture(1'b0);
    checks++; if (cap_ct !== 8'b10011001 || cap_nv !== 8) begin
      failures++; $display("FAIL conflict_next_msg got=%b n=%0d exp=10011001 n=8", cap_ct, cap_nv);
    end
  endtask

  initial begin
    iRst = 1'b0; iEn = 1'b1; iData_in = 1'b0;
    iLoad_key = 1'b0; iLoad_msg = 1'b0; iMode = 1'b0;
    test_reset();
    test_static();
    test_rolling();
    test_no_key();
    test_reset_mid();
    test_enable_freeze();
    test_load_conflict();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xor_cipher_engine.md
XOR_CIPHER_ENGINE -- requirements
Module: xor_cipher_engine

Interface
REQ-001 SHALL have parameter KEY_SIZE, default 4: key width in bits, >= 1.
REQ-002 SHALL have parameter MSG_SIZE, default 8: message width in bits, >= 1, integer multiple of KEY_SIZE; any other value is a configuration error that stops elaboration.
REQ-003 iClk  input  1  single clock; all state updates on the rising edge.
REQ-004 iRst  input  1  reset, synchronous and active-high.
REQ-005 iEn  input  1  clock enable; when 0, every register holds its value.
REQ-006 iData_in  input  1  serial key/message bit, MSB first.
REQ-007 iLoad_key  input  1  key-load strobe; one bit captured per enabled cycle.
REQ-008 iLoad_msg  input  1  message-load strobe; one bit captured per enabled cycle.
REQ-009 iMode  input  1  key mode: 0 = static key, 1 = rolling key; sampled in ENCRYPT.
REQ-010 oData_out  output  1  serial ciphertext bit, MSB first, registered.
REQ-011 oValid  output  1  oData_out carries a ciphertext bit.
REQ-012 oDone_flag  output  1  one enabled-cycle pulse after the last ciphertext bit.
REQ-013 oBusy  output  1  high in ENCRYPT, SHIFT and DONE.
REQ-014 oKey_ready  output  1  key register holds KEY_SIZE valid bits.

Function
REQ-015 SHALL implement FSM states IDLE, ENCRYPT, SHIFT, DONE; transitions occur only on cycles with iEn=1.
REQ-016 IDLE, iLoad_key=1: key shifts left, LSB <= iData_in; key counter increments, saturating at KEY_SIZE; oKey_ready=1 once the counter reaches KEY_SIZE.
REQ-017 After saturation, further key bits keep shifting; the key is always the last KEY_SIZE bits received.
REQ-018 IDLE, iLoad_key=1 and iLoad_msg=1 together: the key load wins and the message bit is discarded.
REQ-019 IDLE, iLoad_msg=1, iLoad_key=0, oKey_ready=1: message shifts left, LSB <= iData_in; message counter increments.
REQ-020 IDLE, iLoad_msg=1 with oKey_ready=0: the bit is ignored and the message counter stays unchanged.
REQ-021 When the MSG_SIZE-th message bit is captured, the FSM SHALL go to ENCRYPT on that same edge.
REQ-022 Assembled key = key register replicated MSG_SIZE/KEY_SIZE times; the key occupies the MSBs of every replica.
REQ-023 ENCRYPT, one cycle:
- ciphertext <= message XOR assembled key.
- If iMode=1, key register rotates left by 1 after use; if iMode=0, key is unchanged.
- Message counter clears.
- Next state SHIFT; on this edge oData_out <= ciphertext MSB and oValid <= 1.
REQ-024 SHIFT presents one ciphertext bit per enabled cycle, MSB first, for exactly MSG_SIZE enabled cycles with oValid=1.
REQ-025 After the last bit, the FSM SHALL enter DONE: oValid=0, oData_out=0, oDone_flag=1 for one enabled cycle, then IDLE with oDone_flag=0.
REQ-026 Latency: last message bit captured at edge k -> first ciphertext bit at edge k+1 -> oDone_flag high from edge k+MSG_SIZE+1 (iEn held 1).
REQ-027 iLoad_key and iLoad_msg SHALL be ignored while oBusy=1; key and partial-message state are unaffected.
REQ-028 iEn=0 in any state freezes the FSM, counters, shift registers and outputs; the sequence resumes exactly where it stopped.
REQ-029 The key register and oKey_ready SHALL persist across messages; only reset clears them.

Reset
REQ-030 iRst=1 at a rising edge, regardless of iEn, SHALL set: state IDLE, key 0, message 0, ciphertext 0, both counters 0, all outputs 0.
REQ-031 Reset mid-operation (any state) SHALL abort with no oDone_flag pulse; the key must be reloaded before the next message is accepted.

Verification
REQ-032 Defaults, iEn=1, iMode=0: key 1010, then message 11001100 -> oValid high 8 cycles, oData_out 0,1,1,0,0,1,1,0, then oDone_flag for one cycle.
REQ-033 iMode=1, key 1010, two messages 11001100 -> first output 01100110; second output 10011001 (key rotated to 0101).
REQ-034 Message 8 bits sent with no key loaded -> oKey_ready=0, oValid never asserts, FSM stays in IDLE.
REQ-035 iRst pulsed on the 3rd SHIFT cycle -> next edge: all outputs 0, oKey_ready=0, no oDone_flag; a following message without key reload is ignored.
REQ-036 iEn=0 for 5 cycles mid-SHIFT -> oData_out and oValid hold; the bit sequence resumes unbroken and still totals 8 bits.
REQ-037 iLoad_key and iLoad_msg high together in IDLE; iLoad_msg toggled during SHIFT -> key shifts, message counter unchanged, ciphertext unaffected.
